// File: rtl/mux2_stream_arb.sv
// Round-robin burst arbiter between two valid/ready streams (A, B). It drives the
// 2:1 mux select and registers every accepted beat onto one output stream.
module mux2_stream_arb #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              sel_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_src_o,
    input  logic              out_ready_i
);

    localparam int                CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last;
    logic                r_sel;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_src;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_burst_done;
    logic                w_last_nxt;
    logic                w_sel_nxt;
    logic                w_can_load;
    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_a_xfer;
    logic                w_b_xfer;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_xfer_data;

    assign w_cnt_inc    = r_cnt + CNT_ONE;
    assign w_burst_done = (w_cnt_inc == CNT_LAST);

    // State register: FSM state, burst counter, last-served pointer and mux select.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Next-state logic: round-robin grant, burst limiting and release on idle source.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (a_valid_i && b_valid_i) begin
                    w_state_nxt = r_last ? ST_GRANT_A : ST_GRANT_B;
                end else if (a_valid_i) begin
                    w_state_nxt = ST_GRANT_A;
                end else if (b_valid_i) begin
                    w_state_nxt = ST_GRANT_B;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT_A: begin
                if (w_a_xfer) begin
                    w_last_nxt = 1'b0;
                    if (w_burst_done) begin
                        w_cnt_nxt   = CNT_ZERO;
                        w_state_nxt = b_valid_i ? ST_GRANT_B : ST_GRANT_A;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = ST_GRANT_A;
                    end
                end else if (!a_valid_i) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = b_valid_i ? ST_GRANT_B : ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt;
                    w_state_nxt = ST_GRANT_A;
                end
            end
            ST_GRANT_B: begin
                if (w_b_xfer) begin
                    w_last_nxt = 1'b1;
                    if (w_burst_done) begin
                        w_cnt_nxt   = CNT_ZERO;
                        w_state_nxt = a_valid_i ? ST_GRANT_A : ST_GRANT_B;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = ST_GRANT_B;
                    end
                end else if (!b_valid_i) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = a_valid_i ? ST_GRANT_A : ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt;
                    w_state_nxt = ST_GRANT_B;
                end
            end
            default: begin
                w_cnt_nxt   = CNT_ZERO;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic: handshakes, accepted-beat mux and the select that follows the grant.
    always_comb begin
        w_can_load  = !r_out_valid || out_ready_i;
        w_a_ready   = !reset && (r_state == ST_GRANT_A) && w_can_load;
        w_b_ready   = !reset && (r_state == ST_GRANT_B) && w_can_load;
        w_a_xfer    = a_valid_i && w_a_ready;
        w_b_xfer    = b_valid_i && w_b_ready;
        w_xfer      = w_a_xfer || w_b_xfer;
        w_xfer_data = w_b_xfer ? b_data_i : a_data_i;
        case (w_state_nxt)
            ST_GRANT_A: w_sel_nxt = 1'b0;
            ST_GRANT_B: w_sel_nxt = 1'b1;
            default:    w_sel_nxt = r_sel;
        endcase
    end

    // Output stage: a transfer loads (even while draining); otherwise downstream empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {DATA_W{1'b0}};
            r_out_src   <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_xfer_data;
            r_out_src   <= w_b_xfer;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= r_out_data;
            r_out_src   <= r_out_src;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_data  <= r_out_data;
            r_out_src   <= r_out_src;
        end
    end

    assign a_ready_o   = w_a_ready;
    assign b_ready_o   = w_b_ready;
    assign sel_o       = r_sel;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_src_o   = r_out_src;

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Bench for mux2_stream_arb: directed scenarios then random traffic, all outputs
// compared every cycle against a channel-indexed reference model and a beat scoreboard.
module tb_mux2_stream_arb;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst, av, bv, ordy;
    logic [DW-1:0] ad, bd;
    logic          a_ready, b_ready, sel, ov, os;
    logic [DW-1:0] od;

    always #5 clk = ~clk;

    mux2_stream_arb #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(rst),
        .a_valid_i(av), .a_data_i(ad), .a_ready_o(a_ready),
        .b_valid_i(bv), .b_data_i(bd), .b_ready_o(b_ready),
        .sel_o(sel), .out_valid_o(ov), .out_data_o(od), .out_src_o(os),
        .out_ready_i(ordy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owner of the grant (-1 none, 0 A, 1 B), beats served in burst.
    int            m_grant;
    int            m_cnt;
    logic          m_sel, m_last, m_ov, m_os;
    logic [DW-1:0] m_od;
    bit            m_xa, m_xb;
    logic [8:0]    sb[$];
    logic [8:0]    drained[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit            v[2];
        logic [DW-1:0] d[2];
        bit            can_load, x;
        int            g, o, nxt;
        m_xa = 1'b0;
        m_xb = 1'b0;
        if (rst) begin
            m_grant = -1; m_cnt = 0; m_sel = 1'b0; m_last = 1'b1;
            m_ov = 1'b0; m_od = 8'h00; m_os = 1'b0;
            sb.delete();
            return;
        end
        v[0] = av; v[1] = bv; d[0] = ad; d[1] = bd;
        can_load = !m_ov || ordy;
        x   = 1'b0;
        nxt = m_grant;
        if (m_grant < 0) begin
            if (v[0] && v[1]) nxt = m_last ? 0 : 1;
            else if (v[0])    nxt = 0;
            else if (v[1])    nxt = 1;
        end else begin
            g = m_grant;
            o = 1 - g;
            if (v[g] && can_load) begin
                x = 1'b1;
                m_last = g[0];
                m_cnt++;
                if (m_cnt == BL) begin
                    m_cnt = 0;
                    nxt = v[o] ? o : g;
                end
                m_od = d[g];
                m_os = g[0];
                sb.push_back({g[0], d[g]});
                if (g == 0) m_xa = 1'b1; else m_xb = 1'b1;
            end else if (!v[g]) begin
                m_cnt = 0;
                nxt = v[o] ? o : -1;
            end
        end
        if (x) m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;
        if (nxt >= 0) m_sel = nxt[0];
        m_grant = nxt;
    endtask

    // One clock: compare every output against the model, advance the model, cross the edge.
    task automatic cycle();
        bit can_load;
        #1;
        can_load = !m_ov || ordy;
        chk("a_ready",   a_ready, (!rst && m_grant == 0 && can_load));
        chk("b_ready",   b_ready, (!rst && m_grant == 1 && can_load));
        chk("sel",       sel, m_sel);
        chk("out_valid", ov,  m_ov);
        chk("out_data",  od,  m_od);
        chk("out_src",   os,  m_os);
        if (!rst && m_ov && ordy) begin
            chk("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) chk("sb_beat", {os, od}, sb.pop_front());
            drained.push_back({os, od});
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp3[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h14,
                             8'h04, 8'h05, 8'h06, 8'h07, 8'h15, 8'h16, 8'h17, 8'h18};

    initial begin
        int ai, bi, nb;
        rst = 1'b1; av = 1'b1; bv = 1'b1; ad = 8'h00; bd = 8'h00; ordy = 1'b1;
        @(posedge clk);
        #1;
        model_step();

        // 1: second reset cycle with both requesting, then A wins the first tie
        cycle();
        chk("t1_out_valid_rst", ov, 0);
        rst = 1'b0;
        cycle();
        chk("t1_first_grant_sel", sel, 0);
        chk("t1_first_grant_a_ready", a_ready, 1);

        // 2: A only, one-cycle latency onto the output register
        bv = 1'b0; ad = 8'h12;
        cycle();
        chk("t2_beat0_data", od, 8'h12);
        chk("t2_beat0_src", os, 0);
        ad = 8'h56;
        cycle();
        chk("t2_beat1_data", od, 8'h56);
        av = 1'b0;
        cycle();
        chk("t2_idle_sel_hold", sel, 0);

        // 3: both streams saturated, bursts of four alternate
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drained.delete();
        ai = 0; bi = 0;
        for (int k = 0; k < 30; k++) begin
            av = (ai < 8); ad = 8'(ai);
            bv = (bi < 8); bd = 8'(8'h11 + bi);
            cycle();
            if (m_xa) ai++;
            if (m_xb) bi++;
        end
        chk("t3_count", drained.size(), 16);
        for (int i = 0; i < 16 && i < drained.size(); i++) chk("t3_order", drained[i][7:0], exp3[i]);

        // 4: backpressure holds data and blocks A; release loads in the draining cycle
        av = 1'b1; bv = 1'b0; ad = 8'h21; ordy = 1'b0;
        cycle();
        cycle();
        ad = 8'h22;
        #1;
        chk("t4_a_ready_bp", a_ready, 0);
        cycle();
        chk("t4_data_hold", od, 8'h21);
        chk("t4_valid_hold", ov, 1);
        ordy = 1'b1;
        #1;
        chk("t4_a_ready_drain", a_ready, 1);
        cycle();
        chk("t4_next_beat", od, 8'h22);
        av = 1'b0;
        cycle();
        cycle();

        // 5: A drops after two beats, B takes over and gets a full burst
        rst = 1'b1;
        cycle();
        rst = 1'b0; av = 1'b1; ad = 8'h31;
        cycle();
        cycle();
        ad = 8'h32;
        cycle();
        av = 1'b0; bv = 1'b1; bd = 8'h41;
        cycle();
        chk("t5_sel_b", sel, 1);
        drained.delete();
        av = 1'b1; ad = 8'h35;
        for (int k = 0; k < 8; k++) begin
            bd = 8'(8'h41 + k);
            cycle();
        end
        nb = 0;
        while (nb < drained.size() && drained[nb][8] == 1'b1) nb++;
        chk("t5_b_burst_len", nb, BL);
        chk("t5_then_a", (drained.size() > BL) ? drained[BL][8] : 1'b1, 0);

        // 6: reset mid-burst discards the held beat; A wins the next tie
        av = 1'b0; bv = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; av = 1'b1; ad = 8'h61;
        cycle();
        cycle();
        cycle();
        rst = 1'b1; bv = 1'b1;
        cycle();
        chk("t6_out_valid_cleared", ov, 0);
        chk("t6_sel_reset", sel, 0);
        rst = 1'b0;
        cycle();
        chk("t6_regrant_sel", sel, 0);
        chk("t6_regrant_a_ready", a_ready, 1);

        // Random traffic with occasional resets
        for (int k = 0; k < 800; k++) begin
            rst  = ($urandom_range(0, 63) == 0);
            av   = ($urandom_range(0, 3) != 0);
            bv   = ($urandom_range(0, 3) != 0);
            ad   = 8'($urandom);
            bd   = 8'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
